inst_fetch_ctrl: RTL and testbench

Sequences the 4-wide instruction-memory port of the superscalar core. Issues fetch requests, holds the address until the memory handshakes, and buffers returned instructions with their PCs in a circular fetch queue. Decode/rename drains the queue at up to 2 instructions per cycle. A redirect input flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_ctrl.sv | 87 ++++++++
 tb/tb_inst_fetch_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: 4-wide fetch sequencer with circular fetch queue and redirect flush
module inst_fetch_ctrl #(
  parameter int DATA_W = 32,
  parameter int QDEPTH = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        InstMem_Read,
  output logic [DATA_W-1:0]           InstMem_Address,
  input  logic                        InstMem_Ready,
  input  logic [DATA_W-1:0]           inst1_in,
  input  logic [DATA_W-1:0]           inst2_in,
  input  logic [DATA_W-1:0]           inst3_in,
  input  logic [DATA_W-1:0]           inst4_in,
  input  logic                        redirect_valid,
  input  logic [DATA_W-1:0]           redirect_pc,
  output logic                        out_valid1,
  output logic                        out_valid2,
  output logic [DATA_W-1:0]           out_inst1,
  output logic [DATA_W-1:0]           out_inst2,
  output logic [DATA_W-1:0]           out_pc1,
  output logic [DATA_W-1:0]           out_pc2,
  input  logic [1:0]                  deq_cnt,
  output logic [$clog2(QDEPTH):0]     q_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] fetch_pc;
  logic [AW-1:0] head, tail, head1;
  logic [DATA_W-1:0] q_inst [QDEPTH];
  logic [DATA_W-1:0] q_pc [QDEPTH];
  logic [DATA_W-1:0] ins [4];
  logic accept;
  logic [1:0] dq, eff;
  assign ins = '{inst1_in, inst2_in, inst3_in, inst4_in};
  assign InstMem_Address = fetch_pc;
  assign InstMem_Read = (state == FETCH) && (q_count <= CW'(QDEPTH - 4));
  assign accept = InstMem_Read && InstMem_Ready && !redirect_valid;
  assign dq = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
  // a request larger than the occupancy only happens when q_count < 2
  assign eff = (CW'(dq) > q_count) ? q_count[1:0] : dq;
  assign head1 = head + AW'(1);
  assign out_valid1 = q_count >= CW'(1);
  assign out_valid2 = q_count >= CW'(2);
  assign out_inst1 = out_valid1 ? q_inst[head] : '0;
  assign out_pc1 = out_valid1 ? q_pc[head] : '0;
  assign out_inst2 = out_valid2 ? q_inst[head1] : '0;
  assign out_pc2 = out_valid2 ? q_pc[head1] : '0;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? FETCH : (redirect_valid ? FLUSH : FETCH);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      q_count <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~DATA_W'(3);
        head <= '0;
        tail <= '0;
        q_count <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + DATA_W'(16);
          tail <= tail + AW'(4);
        end
        head <= head + AW'(eff);
        q_count <= q_count + (accept ? CW'(4) : CW'(0)) - CW'(eff);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept)
      for (int k = 0; k < 4; k++) begin
        q_inst[tail + AW'(k)] <= ins[k];
        q_pc[tail + AW'(k)] <= fetch_pc + DATA_W'(4 * k);
      end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk, rst, rd, ready, redir, v1, v2;
  logic [31:0] addr, i1, i2, i3, i4, rpc, oi1, oi2, op1, op2;
  logic [1:0] deq;
  logic [3:0] q;
  int checks = 0, errors = 0;
  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .InstMem_Read(rd), .InstMem_Address(addr), .InstMem_Ready(ready),
    .inst1_in(i1), .inst2_in(i2), .inst3_in(i3), .inst4_in(i4),
    .redirect_valid(redir), .redirect_pc(rpc),
    .out_valid1(v1), .out_valid2(v2), .out_inst1(oi1), .out_inst2(oi2),
    .out_pc1(op1), .out_pc2(op2), .deq_cnt(deq), .q_count(q)
  );
  assign i1 = addr ^ KEY;
  assign i2 = (addr + 32'd4) ^ KEY;
  assign i3 = (addr + 32'd8) ^ KEY;
  assign i4 = (addr + 32'd12) ^ KEY;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 0; ready = 0; deq = 0; redir = 0; rpc = 0;
    #1;
    chk("rst_read", {31'b0, rd}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_q", {28'b0, q}, 0);
    chk("rst_v1", {31'b0, v1}, 0);
    chk("rst_v2", {31'b0, v2}, 0);
    chk("rst_inst1", oi1, 0);
    chk("rst_pc1", op1, 0);
    #10 rst = 1;
    tick();
    chk("c1_read", {31'b0, rd}, 1);
    chk("c1_addr", addr, 0);
    ready = 1;
    tick();
    chk("c2_q", {28'b0, q}, 4);
    chk("c2_addr", addr, 32'h10);
    chk("c2_read", {31'b0, rd}, 1);
    chk("c2_pc1", op1, 0);
    chk("c2_pc2", op2, 4);
    chk("c2_inst1", oi1, KEY);
    chk("c2_v2", {31'b0, v2}, 1);
    tick();
    chk("full_q", {28'b0, q}, 8);
    chk("full_read", {31'b0, rd}, 0);
    chk("full_addr", addr, 32'h20);
    deq = 2;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("drain_pc1", op1, 32'(8 * i));
      chk("drain_pc2", op2, 32'(8 * i + 4));
      chk("drain_inst1", oi1, 32'(8 * i) ^ KEY);
      chk("drain_q", {28'b0, q}, (i % 2 == 1) ? 6 : 4);
    end
    ready = 0; deq = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("deq1_q", {28'b0, q}, 32'(6 - i));
    end
    chk("q1_pc1", op1, 32'h3C);
    chk("q1_v1", {31'b0, v1}, 1);
    chk("q1_v2", {31'b0, v2}, 0);
    chk("hold_addr", addr, 32'h40);
    deq = 2;
    tick();
    chk("clamp_q", {28'b0, q}, 0);
    chk("clamp_v1", {31'b0, v1}, 0);
    chk("clamp_read", {31'b0, rd}, 1);
    chk("clamp_addr", addr, 32'h40);
    deq = 3;
    tick();
    chk("deq3_empty_q", {28'b0, q}, 0);
    deq = 0; ready = 1; redir = 1; rpc = 32'h1237;
    tick();
    chk("rd_q", {28'b0, q}, 0);
    chk("rd_read", {31'b0, rd}, 0);
    chk("rd_addr", addr, 32'h1234);
    chk("rd_v1", {31'b0, v1}, 0);
    redir = 0;
    tick();
    chk("rd2_read", {31'b0, rd}, 1);
    chk("rd2_addr", addr, 32'h1234);
    chk("rd2_q", {28'b0, q}, 0);
    tick();
    chk("rd3_q", {28'b0, q}, 4);
    chk("rd3_pc1", op1, 32'h1234);
    chk("rd3_pc2", op2, 32'h1238);
    chk("rd3_inst2", oi2, 32'h1238 ^ KEY);
    chk("rd3_addr", addr, 32'h1244);
    redir = 1; rpc = 32'h5557;
    tick();
    chk("b2b1_addr", addr, 32'h5554);
    chk("b2b1_read", {31'b0, rd}, 0);
    chk("b2b1_q", {28'b0, q}, 0);
    rpc = 32'hFFFF_FFF1;
    tick();
    chk("b2b2_addr", addr, 32'hFFFF_FFF0);
    chk("b2b2_read", {31'b0, rd}, 0);
    redir = 0;
    tick();
    chk("wrap_read", {31'b0, rd}, 1);
    chk("wrap_q0", {28'b0, q}, 0);
    tick();
    chk("wrap_q", {28'b0, q}, 4);
    chk("wrap_pc1", op1, 32'hFFFF_FFF0);
    chk("wrap_pc2", op2, 32'hFFFF_FFF4);
    chk("wrap_addr", addr, 32'h0);
    ready = 0; deq = 2;
    tick();
    chk("wrap2_q", {28'b0, q}, 2);
    chk("wrap2_pc1", op1, 32'hFFFF_FFF8);
    chk("wrap2_pc2", op2, 32'hFFFF_FFFC);
    chk("wrap2_inst2", oi2, 32'hFFFF_FFFC ^ KEY);
    chk("wrap2_read", {31'b0, rd}, 1);
    #2 rst = 0; deq = 0;
    #1;
    chk("async_read", {31'b0, rd}, 0);
    chk("async_q", {28'b0, q}, 0);
    chk("async_addr", addr, 0);
    chk("async_v1", {31'b0, v1}, 0);
    rst = 1;
    tick();
    chk("lat1_read", {31'b0, rd}, 1);
    chk("lat1_addr", addr, 0);
    tick();
    chk("lat2_addr", addr, 0);
    chk("lat2_q", {28'b0, q}, 0);
    tick();
    chk("lat3_addr", addr, 0);
    chk("lat3_read", {31'b0, rd}, 1);
    ready = 1;
    tick();
    chk("lat4_q", {28'b0, q}, 4);
    chk("lat4_addr", addr, 32'h10);
    chk("lat4_pc1", op1, 0);
    ready = 0;
    tick();
    chk("lat5_q", {28'b0, q}, 4);
    chk("lat5_addr", addr, 32'h10);
    rst = 0;
    #1 rst = 1; redir = 1; rpc = 32'h102;
    tick();
    chk("idle_rd_read", {31'b0, rd}, 1);
    chk("idle_rd_addr", addr, 32'h100);
    chk("idle_rd_q", {28'b0, q}, 0);
    redir = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
